main_control_fsm: RTL

- Multi-cycle main control unit for the MiniMIPS core.
- Decodes the 4-bit opcode and sequences fetch, decode, execute, memory and writeback.
- Drives alu_op into alu_control, which resolves R-type func codes.
- Stalls on a ready/valid-style memory handshake and gates PC updates for branches.

---
 rtl/mips_ctrl_pkg.sv | 55 +++++
 rtl/main_control_fsm_if.sv | 35 +++
 rtl/mem_wait_counter.sv | 22 ++
 rtl/main_control_fsm.sv | 132 +++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcodes, ALU selects, mux encodings and FSM states shared by the
// MiniMIPS control path and alu_control.
package mips_ctrl_pkg;
    localparam logic [3:0] OP_RTYPE = 4'd0;
    localparam logic [3:0] OP_ADDI  = 4'd1;
    localparam logic [3:0] OP_ANDI  = 4'd2;
    localparam logic [3:0] OP_ORI   = 4'd3;
    localparam logic [3:0] OP_SLTI  = 4'd4;
    localparam logic [3:0] OP_LW    = 4'd5;
    localparam logic [3:0] OP_SW    = 4'd6;
    localparam logic [3:0] OP_BEQ   = 4'd7;
    localparam logic [3:0] OP_BNE   = 4'd8;
    localparam logic [3:0] OP_J     = 4'd9;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_XOR   = 3'b001;
    localparam logic [2:0] ALU_SUB   = 3'b010;
    localparam logic [2:0] ALU_RTYPE = 3'b011;
    localparam logic [2:0] ALU_SLT   = 3'b100;
    localparam logic [2:0] ALU_NOR   = 3'b101;
    localparam logic [2:0] ALU_AND   = 3'b110;
    localparam logic [2:0] ALU_OR    = 3'b111;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_TWO    = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU, S_MEM_ADDR,
        S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP
    } state_t;

    function automatic logic is_illegal(logic [3:0] op);
        return op > OP_J;
    endfunction

    function automatic logic [2:0] i_alu_op(logic [3:0] op);
        return (op == OP_ANDI) ? ALU_AND :
               (op == OP_ORI)  ? ALU_OR  :
               (op == OP_SLTI) ? ALU_SLT : ALU_ADD;
    endfunction

    function automatic state_t decode_next(logic [3:0] op);
        return (op == OP_RTYPE)                  ? S_EXEC_R   :
               (op >= OP_ADDI && op <= OP_SLTI)  ? S_EXEC_I   :
               (op == OP_LW || op == OP_SW)      ? S_MEM_ADDR :
               (op == OP_BEQ || op == OP_BNE)    ? S_BRANCH   :
               (op == OP_J)                      ? S_JUMP     : S_FETCH;
    endfunction
endpackage

// File: rtl/main_control_fsm_if.sv
// main_control_fsm_if: datapath-facing control bundle; master is the FSM, slave the datapath.
interface main_control_fsm_if;
    logic [3:0] opcode;
    logic       alu_zero;
    logic       mem_ready;
    logic [2:0] alu_op;
    logic       pc_en;
    logic [1:0] pc_source;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       instr_done;
    logic       illegal_op;
    logic       mem_timeout;
    logic [3:0] wait_count;

    modport master (
        input  opcode, alu_zero, mem_ready,
        output alu_op, pc_en, pc_source, ir_write, i_or_d, mem_read, mem_write,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               instr_done, illegal_op, mem_timeout, wait_count
    );
    modport slave (
        output opcode, alu_zero, mem_ready,
        input  alu_op, pc_en, pc_source, ir_write, i_or_d, mem_read, mem_write,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
               instr_done, illegal_op, mem_timeout, wait_count
    );
endinterface

// File: rtl/mem_wait_counter.sv
// mem_wait_counter: saturating count of consecutive memory wait cycles with a
// single timeout pulse on the cycle the count reaches MEM_WAIT_MAX.
module mem_wait_counter #(
    parameter logic [3:0] MEM_WAIT_MAX = 4'd15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       waiting,
    input  logic       clear,
    output logic [3:0] count,
    output logic       timeout
);
    always_ff @(posedge clk) begin
        if (!rst_n || clear)
            count <= 4'd0;
        else if (waiting && count != MEM_WAIT_MAX)
            count <= count + 4'd1;
    end

    // Fires during the wait cycle that brings the count to the limit, so only once.
    assign timeout = waiting && !clear && count == MEM_WAIT_MAX - 4'd1;
endmodule

// File: rtl/main_control_fsm.sv
// main_control_fsm: multi-cycle MiniMIPS control unit sequencing fetch, decode,
// execute, memory and writeback with a ready-gated memory handshake.
module main_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter logic [3:0] MEM_WAIT_MAX = 4'd15
) (
    input  logic                clk,
    input  logic                rst_n,
    main_control_fsm_if.master  bus
);
    state_t state;
    logic   is_r;
    logic   is_bne;
    logic   waiting;
    logic   timeout;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_FETCH;
            is_r   <= 1'b0;
            is_bne <= 1'b0;
        end else begin
            case (state)
                S_FETCH:    if (bus.mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    is_r   <= bus.opcode == OP_RTYPE;
                    is_bne <= bus.opcode == OP_BNE;
                    state  <= decode_next(bus.opcode);
                end
                S_EXEC_R,
                S_EXEC_I:   state <= S_WB_ALU;
                S_MEM_ADDR: state <= (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD:   if (bus.mem_ready) state <= S_MEM_WB;
                S_MEM_WR:   if (bus.mem_ready) state <= S_FETCH;
                default:    state <= S_FETCH;
            endcase
        end
    end

    assign waiting = rst_n && !bus.mem_ready &&
                     (state == S_FETCH || state == S_MEM_RD || state == S_MEM_WR);

    // A non-waiting cycle is exactly mem_ready or a state that always advances.
    mem_wait_counter #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_wait (
        .clk     (clk),
        .rst_n   (rst_n),
        .waiting (waiting),
        .clear   (!waiting),
        .count   (bus.wait_count),
        .timeout (timeout)
    );

    assign bus.mem_timeout = timeout;

    always_comb begin
        bus.alu_op     = ALU_ADD;
        bus.pc_en      = 1'b0;
        bus.pc_source  = PC_ALU;
        bus.ir_write   = 1'b0;
        bus.i_or_d     = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = SRCB_RT;
        bus.instr_done = 1'b0;
        bus.illegal_op = 1'b0;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    bus.mem_read  = 1'b1;
                    bus.alu_src_b = SRCB_TWO;
                    bus.ir_write  = bus.mem_ready;
                    bus.pc_en     = bus.mem_ready;
                end
                S_DECODE: begin
                    bus.alu_src_b  = SRCB_IMM_SH;
                    bus.illegal_op = is_illegal(bus.opcode);
                    bus.instr_done = is_illegal(bus.opcode);
                end
                S_EXEC_R: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = ALU_RTYPE;
                end
                S_EXEC_I: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = SRCB_IMM;
                    bus.alu_op    = i_alu_op(bus.opcode);
                end
                S_WB_ALU: begin
                    bus.reg_write  = 1'b1;
                    bus.reg_dst    = is_r;
                    bus.instr_done = 1'b1;
                end
                S_MEM_ADDR: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = SRCB_IMM;
                end
                S_MEM_RD: begin
                    bus.mem_read = 1'b1;
                    bus.i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_MEM_WR: begin
                    bus.mem_write  = 1'b1;
                    bus.i_or_d     = 1'b1;
                    bus.instr_done = bus.mem_ready;
                end
                S_BRANCH: begin
                    bus.alu_src_a  = 1'b1;
                    bus.alu_op     = ALU_SUB;
                    bus.pc_source  = PC_ALUOUT;
                    bus.pc_en      = bus.alu_zero ^ is_bne;
                    bus.instr_done = 1'b1;
                end
                S_JUMP: begin
                    bus.pc_source  = PC_JUMP;
                    bus.pc_en      = 1'b1;
                    bus.instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
